// File: rtl/comet_ii_decode_seq_if.sv
// Instruction-fetch bus between instruction memory (master) and the
// COMET II decoder (slave).
//
// Handshake: a word transfers on every posedge where iw_valid and iw_ready
// are both 1. The master holds iw_data stable while iw_valid is high and the
// word has not transferred yet. iw_ready depends only on decoder state, never
// on iw_valid.
interface comet_ii_decode_seq_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] iw_data;
  logic              iw_valid;
  logic              iw_ready;

  modport master (output iw_data, output iw_valid, input iw_ready);
  modport slave  (input iw_data, input iw_valid, output iw_ready);
endinterface

// File: rtl/comet_ii_decode_seq.sv
// COMET II decoder / sequencer.
// Fetches instruction words through a small prefetch FIFO, splits 1- and
// 2-word instructions, and drives registered ALU mode and control strobes.
// The IDLE/INIT/IFET1/IFET2/EXEC/WBACK state is visible on o_state.
// Optional feature: define COMET_DEC_ILLEGAL_TRAP_EN to trap undefined
// opcodes (sticky o_illegal, return to IDLE, FIFO flush). Without it,
// undefined opcodes run as a 1-word NOP.
module comet_ii_decode_seq #(
  parameter int WORD_W   = 16,
  parameter int REG_W    = 4,
  parameter int PF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comet_ii_decode_seq_if.slave iw_bus,
  input  logic                 i_start,
  input  logic [2:0]           i_fr,        // {OF,SF,ZF}
  input  logic                 i_exec_done,
  output logic [2:0]           o_state,
  output logic [7:0]           o_op_code,
  output logic [REG_W-1:0]     o_r_r1,
  output logic [REG_W-1:0]     o_x_r2,
  output logic [WORD_W-1:0]    o_adr,
  output logic [3:0]           o_alu_mode,
  output logic [11:0]          o_ctrl,      // {inc_PR,r_adr_x,r1_r2,ld,store,lad,jump,dec_SP,push,pop,call,ret}
  output logic                 o_illegal
);
  localparam int PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_IFET1 = 3'd2,
    S_IFET2 = 3'd3,
    S_EXEC  = 3'd4,
    S_WBACK = 3'd5
  } state_t;

  state_t              r_state, w_state_n;
  logic [WORD_W-1:0]   r_mem [PF_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_n;
  logic                w_push, w_pop, w_flush;
  logic [WORD_W-1:0]   w_head;
  logic [7:0]          w_head_op;
  logic [7:0]          r_op, w_op_n;
  logic [REG_W-1:0]    r_r1, w_r1_n, r_x2, w_x2_n;
  logic [WORD_W-1:0]   r_adr, w_adr_n;
  logic [3:0]          r_alu, w_alu_n;
  logic [11:0]         r_ctrl, w_ctrl_n;
  logic                r_illegal, w_illegal_n;

  // Opcodes that belong to the COMET II instruction set (SVC excluded).
  function automatic logic f_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h10, 8'h11, 8'h12, 8'h14,
      8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
      8'h30, 8'h31, 8'h32, 8'h34, 8'h35, 8'h36,
      8'h40, 8'h41, 8'h44, 8'h45,
      8'h50, 8'h51, 8'h52, 8'h53,
      8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
      8'h70, 8'h71, 8'h80, 8'h81: f_legal = 1'b1;
      default:                    f_legal = 1'b0;
    endcase
  endfunction

  // Unknown opcodes are always treated as 1-word.
  function automatic logic f_two_word(input logic [7:0] op);
    f_two_word = f_legal(op) &&
                 ((op[7:4] == 4'h6) ||
                  (!op[2] && op != 8'h00 && op != 8'h71 && op != 8'h81));
  endfunction

  // Bit 2 is masked so register forms share the memory-form ALU code.
  function automatic logic [3:0] f_alu(input logic [7:0] op);
    logic [3:0] m;
    case (op & 8'hFB)
      8'h10:   m = 4'h7;
      8'h20:   m = 4'h8;
      8'h21:   m = 4'h9;
      8'h22:   m = 4'hA;
      8'h23:   m = 4'hB;
      8'h30:   m = 4'hC;
      8'h31:   m = 4'hD;
      8'h32:   m = 4'hE;
      8'h40:   m = 4'h0;
      8'h41:   m = 4'h1;
      8'h52:   m = 4'h2;
      8'h53:   m = 4'h3;
      8'h50:   m = 4'h4;
      8'h51:   m = 4'h5;
      default: m = 4'hF;
    endcase
    f_alu = f_legal(op) ? m : 4'hF;
  endfunction

  // EXEC-cycle strobes; undefined opcodes produce all zeros.
  function automatic logic [11:0] f_exec_ctrl(input logic [7:0] op,
                                              input logic [3:0] alu,
                                              input logic [2:0] fr);
    logic [11:0] c;
    c = '0;
    if (f_legal(op)) begin
      if (alu != 4'hF)                    c[10:9] = (op[3:2] == 2'b00) ? 2'b10 : 2'b01;
      else if (op == 8'h71 || op == 8'h81) c[10:9] = 2'b00;
      else                                c[10:9] = 2'b10;
      c[8] = (alu != 4'hF) && (op[7:4] != 4'h4);
      c[7] = (op == 8'h11);
      c[6] = (op == 8'h12);
      case (op)
        8'h61:                c[5] = fr[1];
        8'h62:                c[5] = !fr[0];
        8'h63:                c[5] = fr[0];
        8'h64, 8'h80, 8'h81:  c[5] = 1'b1;
        8'h65:                c[5] = !fr[1] && !fr[0];
        8'h66:                c[5] = fr[2];
        default:              c[5] = 1'b0;
      endcase
      c[3] = (op == 8'h70);
      c[2] = (op == 8'h71);
      c[1] = (op == 8'h80);
      c[0] = (op == 8'h81);
    end
    f_exec_ctrl = c;
  endfunction

  assign iw_bus.iw_ready = (r_count != FULL_CNT);
  assign w_push    = iw_bus.iw_valid && iw_bus.iw_ready;
  assign w_pop     = ((r_state == S_IFET1) || (r_state == S_IFET2)) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[WORD_W-1 -: 8];

  // Next state, next latched fields and next strobes (strobes follow the next state).
  always_comb begin
    w_state_n   = r_state;
    w_op_n      = r_op;
    w_r1_n      = r_r1;
    w_x2_n      = r_x2;
    w_adr_n     = r_adr;
    w_alu_n     = r_alu;
    w_illegal_n = r_illegal;
    w_flush     = 1'b0;
    w_ctrl_n    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_n   = S_INIT;
          w_illegal_n = 1'b0;
        end
      end
      S_INIT: w_state_n = S_IFET1;
      S_IFET1: begin
        if (w_pop) begin
          w_op_n  = w_head_op;
          w_r1_n  = w_head[WORD_W-9 -: REG_W];
          w_x2_n  = w_head[WORD_W-9-REG_W -: REG_W];
          w_adr_n = '0;
          w_alu_n = f_alu(w_head_op);
`ifdef COMET_DEC_ILLEGAL_TRAP_EN
          if (!f_legal(w_head_op)) begin
            w_illegal_n = 1'b1;
            w_flush     = 1'b1;
            w_state_n   = S_IDLE;
          end else
`endif
          if (f_two_word(w_head_op)) w_state_n = S_IFET2;
          else                       w_state_n = S_EXEC;
        end
      end
      S_IFET2: begin
        if (w_pop) begin
          w_adr_n   = w_head;
          w_state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_exec_done) begin
          // A taken jump discards everything prefetched, including this cycle's word.
          w_flush   = r_ctrl[5];
          w_state_n = r_ctrl[8] ? S_WBACK : S_IFET1;
        end
      end
      S_WBACK: w_state_n = S_IFET1;
      default: w_state_n = S_IDLE;
    endcase

    if (w_flush) w_count_n = '0;
    else         w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    case (w_state_n)
      S_IFET2: begin
        w_ctrl_n[10] = 1'b1;
        w_ctrl_n[4]  = (w_op_n == 8'h70) || (w_op_n == 8'h80);
      end
      S_EXEC:  w_ctrl_n = f_exec_ctrl(w_op_n, w_alu_n, i_fr);
      default: w_ctrl_n = '0;
    endcase
    // A fetch state with a non-empty FIFO pops in that cycle.
    if (w_state_n == S_IFET1 || w_state_n == S_IFET2)
      w_ctrl_n[11] = (w_count_n != '0);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  // Prefetch FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_n;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk) begin
    if (rst_n && w_push && !w_flush) r_mem[r_wr_ptr] <= iw_bus.iw_data;
  end

  // Latched instruction fields and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_r1      <= '0;
      r_x2      <= '0;
      r_adr     <= '0;
      r_alu     <= 4'hF;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_op      <= w_op_n;
      r_r1      <= w_r1_n;
      r_x2      <= w_x2_n;
      r_adr     <= w_adr_n;
      r_alu     <= w_alu_n;
      r_ctrl    <= w_ctrl_n;
      r_illegal <= w_illegal_n;
    end
  end

  assign o_state    = r_state;
  assign o_op_code  = r_op;
  assign o_r_r1     = r_r1;
  assign o_x_r2     = r_x2;
  assign o_adr      = r_adr;
  assign o_alu_mode = r_alu;
  assign o_ctrl     = r_ctrl;
  assign o_illegal  = r_illegal;
endmodule

// File: tb/tb_comet_ii_decode_seq.sv
// Directed bench for comet_ii_decode_seq. Inputs change on the falling edge,
// outputs are checked on the falling edge, i.e. half a cycle after each posedge.
module tb_comet_ii_decode_seq;
  localparam int WORD_W   = 16;
  localparam int REG_W    = 4;
  localparam int PF_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        fr = 3'b000;
  logic              exec_done = 1'b0;
  logic [2:0]        o_state;
  logic [7:0]        o_op_code;
  logic [REG_W-1:0]  o_r_r1, o_x_r2;
  logic [WORD_W-1:0] o_adr;
  logic [3:0]        o_alu_mode;
  logic [11:0]       o_ctrl;
  logic              o_illegal;

  comet_ii_decode_seq_if #(.WORD_W(WORD_W)) bus ();

  comet_ii_decode_seq #(.WORD_W(WORD_W), .REG_W(REG_W), .PF_DEPTH(PF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .iw_bus(bus), .i_start(start), .i_fr(fr),
    .i_exec_done(exec_done), .o_state(o_state), .o_op_code(o_op_code),
    .o_r_r1(o_r_r1), .o_x_r2(o_x_r2), .o_adr(o_adr), .o_alu_mode(o_alu_mode),
    .o_ctrl(o_ctrl), .o_illegal(o_illegal)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_inc    = 0;
  logic [WORD_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_sc(input string tag, input logic [2:0] st, input logic [11:0] ctrl);
    check({tag, "_state"}, {29'd0, o_state}, {29'd0, st});
    check({tag, "_ctrl"}, {20'd0, o_ctrl}, {20'd0, ctrl});
  endtask

  initial begin
    bus.iw_valid = 1'b0;
    bus.iw_data  = '0;
    cyc(); cyc();
    // reset state
    check_sc("rst", 3'd0, 12'h000);
    check("rst_alu", o_alu_mode, 4'hF);
    check("rst_op", o_op_code, 8'h00);
    check("rst_adr", o_adr, 16'h0000);
    check("rst_ready", bus.iw_ready, 1'b1);
    check("rst_illegal", o_illegal, 1'b0);

    // T1: LD 1000, 0040
    rst_n = 1'b1; start = 1'b1; bus.iw_valid = 1'b1; bus.iw_data = 16'h1000;
    exp_q.push_back(16'h0040);
    cyc(); check_sc("t1_init", 3'd1, 12'h000);
    start = 1'b0; bus.iw_data = 16'h0040;
    cyc(); check_sc("t1_ifet1", 3'd2, 12'h800); n_inc += int'(o_ctrl[11]);
    bus.iw_valid = 1'b0;
    cyc(); check_sc("t1_ifet2", 3'd3, 12'hC00); n_inc += int'(o_ctrl[11]);
    check("t1_op", o_op_code, 8'h10);
    check("t1_alu", o_alu_mode, 4'h7);
    cyc(); check_sc("t1_exec", 3'd4, 12'h500); n_inc += int'(o_ctrl[11]);
    check("t1_adr", o_adr, exp_q.pop_front());
    exec_done = 1'b1;
    cyc(); check_sc("t1_wback", 3'd5, 12'h000);
    exec_done = 1'b0;
    cyc(); check_sc("t1_back", 3'd2, 12'h000);
    check("t1_inc_count", n_inc, 2);

    // T2: ADDA r,r 2412
    bus.iw_valid = 1'b1; bus.iw_data = 16'h2412;
    cyc(); check_sc("t2_ifet1", 3'd2, 12'h800);
    bus.iw_valid = 1'b0;
    cyc(); check_sc("t2_exec", 3'd4, 12'h300);
    check("t2_alu", o_alu_mode, 4'h8);
    check("t2_adr", o_adr, 16'h0000);
    check("t2_r1", o_r_r1, 4'h1);
    check("t2_x2", o_x_r2, 4'h2);
    exec_done = 1'b1;
    cyc(); check_sc("t2_wback", 3'd5, 12'h000);
    exec_done = 1'b0;
    cyc(); check_sc("t2_back", 3'd2, 12'h000);

    // T3: JZE 6300,0100 taken with a full FIFO
    fr = 3'b001; bus.iw_valid = 1'b1; bus.iw_data = 16'h6300;
    cyc(); check_sc("t3_ifet1", 3'd2, 12'h800);
    bus.iw_data = 16'h0100;
    cyc(); check_sc("t3_ifet2", 3'd3, 12'hC00);
    bus.iw_data = 16'hAAAA;
    cyc(); check_sc("t3_exec", 3'd4, 12'h420);
    check("t3_adr", o_adr, 16'h0100);
    bus.iw_data = 16'hBBBB;
    cyc(); check("t3_full_ready", bus.iw_ready, 1'b0);
    check_sc("t3_hold", 3'd4, 12'h420);
    exec_done = 1'b1; bus.iw_data = 16'hCCCC;
    cyc(); check_sc("t3_flush", 3'd2, 12'h000);
    check("t3_ready", bus.iw_ready, 1'b1);
    bus.iw_valid = 1'b0; exec_done = 1'b0;
    cyc(); check_sc("t3_empty", 3'd2, 12'h000);

    // T4: PUSH 7000,0005 with exec_done late
    fr = 3'b000; bus.iw_valid = 1'b1; bus.iw_data = 16'h7000;
    cyc(); check_sc("t4_ifet1", 3'd2, 12'h800);
    bus.iw_data = 16'h0005;
    cyc(); check_sc("t4_ifet2", 3'd3, 12'hC10);
    bus.iw_valid = 1'b0;
    cyc(); check("t4_adr", o_adr, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      check_sc($sformatf("t4_exec%0d", i), 3'd4, 12'h408);
      exec_done = (i == 2);
      cyc();
    end
    exec_done = 1'b0;
    check_sc("t4_back", 3'd2, 12'h000);

    // T5: back-pressure with no pops (sequencer in IDLE)
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; bus.iw_valid = 1'b1; bus.iw_data = 16'h1000;
    cyc(); check("t5_ready1", bus.iw_ready, 1'b1);
    bus.iw_data = 16'h0077; exp_q.push_back(16'h0077);
    cyc(); check("t5_ready2", bus.iw_ready, 1'b0);
    bus.iw_data = 16'h5555;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("t5_hold%0d", i), bus.iw_ready, 1'b0);
    end
    bus.iw_valid = 1'b0; start = 1'b1;
    cyc(); check_sc("t5_init", 3'd1, 12'h000);
    start = 1'b0;
    cyc(); check_sc("t5_ifet1", 3'd2, 12'h800);
    cyc(); check_sc("t5_ifet2", 3'd3, 12'hC00);
    check("t5_op", o_op_code, 8'h10);
    cyc(); check_sc("t5_exec", 3'd4, 12'h500);
    check("t5_adr", o_adr, exp_q.pop_front());

    // T6: reset in the middle of EXEC, with a word offered
    bus.iw_valid = 1'b1; bus.iw_data = 16'h1234; rst_n = 1'b0;
    cyc(); check_sc("t6_rst", 3'd0, 12'h000);
    check("t6_ready", bus.iw_ready, 1'b1);
    check("t6_op", o_op_code, 8'h00);
    check("t6_alu", o_alu_mode, 4'hF);
    check("t6_adr", o_adr, 16'h0000);
    rst_n = 1'b1; start = 1'b1; bus.iw_data = 16'h9900;
    cyc(); check_sc("t6_init", 3'd1, 12'h000);
    start = 1'b0; bus.iw_valid = 1'b0;
    cyc(); check_sc("t6_ifet1", 3'd2, 12'h800);
    cyc();
`ifdef COMET_DEC_ILLEGAL_TRAP_EN
    check_sc("t6_trap", 3'd0, 12'h000);
    check("t6_illegal", o_illegal, 1'b1);
    check("t6_trap_op", o_op_code, 8'h99);
    start = 1'b1;
    cyc(); check("t6_illegal_clr", o_illegal, 1'b0);
    check_sc("t6_restart", 3'd1, 12'h000);
    start = 1'b0;
`else
    check_sc("t6_nop", 3'd4, 12'h000);
    check("t6_illegal", o_illegal, 1'b0);
    check("t6_nop_alu", o_alu_mode, 4'hF);
    exec_done = 1'b1;
    cyc(); check_sc("t6_nop_back", 3'd2, 12'h000);
    exec_done = 1'b0;
`endif

    // T7: POP 7100 then JNZ 6200,0200 (not taken, then live fr makes it taken)
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; start = 1'b1; bus.iw_valid = 1'b1; bus.iw_data = 16'h7100;
    cyc();
    start = 1'b0; bus.iw_data = 16'h6200;
    cyc(); check_sc("t7_ifet1", 3'd2, 12'h800);
    bus.iw_valid = 1'b0; fr = 3'b001;
    cyc(); check_sc("t7_pop", 3'd4, 12'h004);
    exec_done = 1'b1;
    cyc(); check_sc("t7_noflush", 3'd2, 12'h800);
    exec_done = 1'b0; bus.iw_valid = 1'b1; bus.iw_data = 16'h0200;
    cyc(); check_sc("t7_ifet2", 3'd3, 12'hC00);
    bus.iw_valid = 1'b0;
    cyc(); check_sc("t7_jnz_nt", 3'd4, 12'h400);
    check("t7_adr", o_adr, 16'h0200);
    fr = 3'b000;
    cyc(); check_sc("t7_jnz_t", 3'd4, 12'h420);
    exec_done = 1'b1; bus.iw_valid = 1'b1; bus.iw_data = 16'h1400;
    cyc(); check_sc("t7_drop", 3'd2, 12'h000);
    check("t7_ready", bus.iw_ready, 1'b1);
    exec_done = 1'b0; bus.iw_valid = 1'b0;
    cyc(); check_sc("t7_empty", 3'd2, 12'h000);

    // report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
